// File: rtl/memoria_instrucoes_carregavel.sv
// Loadable instruction memory: a loader streams words in (CARGA), then fetches read them (EXECUCAO).
// Latency: load writes 1 word/cycle; fetch result is registered, valid 1 cycle after the request.
// Backpressure: carga_pronto is high only in CARGA; fetches are always accepted in EXECUCAO.
// Optional fetch counter enabled by defining MEM_INSTR_CONTADOR_EN; without it contador_buscas is 0.
module memoria_instrucoes_carregavel #(
    parameter int LARGURA      = 32,
    parameter int PROFUNDIDADE = 1024,
    parameter int LARGURA_END  = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   carga_inicio,
    input  logic                   carga_valido,
    input  logic [LARGURA-1:0]     carga_dado,
    input  logic                   carga_fim,
    output logic                   carga_pronto,
    output logic                   carga_completa,
    output logic [LARGURA_END:0]   palavras_carregadas,
    input  logic [31:0]            endereco,
    input  logic                   busca_valida,
    output logic [LARGURA-1:0]     instrucao,
    output logic                   instrucao_valida,
    output logic                   erro_endereco,
    output logic [31:0]            contador_buscas
);

    typedef enum logic {
        CARGA    = 1'b0,
        EXECUCAO = 1'b1
    } estado_t;

    // Index of the last word; writing it ends the load on its own.
    localparam logic [LARGURA_END:0] ULTIMO = (LARGURA_END+1)'(PROFUNDIDADE - 1);
    localparam logic [31:0]          LIMITE = 32'(PROFUNDIDADE);
    localparam logic [LARGURA_END:0] UM     = (LARGURA_END+1)'(1);

    estado_t                estado_q, estado_d;
    // The word count doubles as the write pointer: both advance together and clear together.
    logic [LARGURA_END:0]   palavras_q, palavras_d;
    logic                   completa_q, completa_d;
    logic [LARGURA-1:0]     instrucao_q, instrucao_d;
    logic                   valida_q, valida_d;
    logic                   erro_q, erro_d;

    logic [LARGURA-1:0]     mem [PROFUNDIDADE];
    logic                   escreve;
    logic                   busca_aceita;
    logic                   em_faixa;
    logic [LARGURA_END-1:0] idx_escrita;
    logic [LARGURA_END-1:0] idx_leitura;

    assign idx_escrita = palavras_q[LARGURA_END-1:0];
    assign idx_leitura = endereco[LARGURA_END-1:0];
    // Full 32-bit compare so high addresses never alias onto low words.
    assign em_faixa    = (endereco < LIMITE);

    // Next state, load bookkeeping and fetch acceptance.
    always_comb begin
        estado_d     = estado_q;
        palavras_d   = palavras_q;
        escreve      = 1'b0;
        busca_aceita = 1'b0;
        case (estado_q)
            CARGA: begin
                if (carga_valido) begin
                    escreve    = 1'b1;
                    palavras_d = palavras_q + UM;
                    if (palavras_q == ULTIMO) begin
                        estado_d = EXECUCAO;
                    end
                end
                // A word presented together with carga_fim is still written and counted above.
                if (carga_fim) begin
                    estado_d = EXECUCAO;
                end
            end
            EXECUCAO: begin
                busca_aceita = busca_valida;
                if (carga_inicio) begin
                    estado_d   = CARGA;
                    palavras_d = '0;
                end
            end
        endcase
        completa_d = (estado_d == EXECUCAO);
    end

    // Fetch result: in-range reads the array, out-of-range yields a NOP and flags the error.
    // instrucao_valida marks only real array reads; an error fetch raises erro_endereco instead.
    always_comb begin
        instrucao_d = instrucao_q;
        valida_d    = 1'b0;
        erro_d      = 1'b0;
        if (busca_aceita) begin
            if (em_faixa) begin
                instrucao_d = mem[idx_leitura];
                valida_d    = 1'b1;
            end else begin
                instrucao_d = '0;
                erro_d      = 1'b1;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= CARGA;
            palavras_q  <= '0;
            completa_q  <= 1'b0;
            instrucao_q <= '0;
            valida_q    <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            palavras_q  <= palavras_d;
            completa_q  <= completa_d;
            instrucao_q <= instrucao_d;
            valida_q    <= valida_d;
            erro_q      <= erro_d;
        end
    end

    // Array write port; contents survive reset so a reload can reuse them.
    always_ff @(posedge clock) begin
        if (!reset && escreve) begin
            mem[idx_escrita] <= carga_dado;
        end
    end

`ifdef MEM_INSTR_CONTADOR_EN
    logic [31:0] contador_q, contador_d;

    // Saturating count of accepted fetches; returning to CARGA restarts it.
    always_comb begin
        contador_d = contador_q;
        if (estado_q == EXECUCAO && carga_inicio) begin
            contador_d = '0;
        end else if (busca_aceita && contador_q != 32'hFFFF_FFFF) begin
            contador_d = contador_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            contador_q <= '0;
        end else begin
            contador_q <= contador_d;
        end
    end

    assign contador_buscas = contador_q;
`else
    assign contador_buscas = '0;
`endif

    assign carga_pronto        = (estado_q == CARGA);
    assign carga_completa      = completa_q;
    assign palavras_carregadas = palavras_q;
    assign instrucao           = instrucao_q;
    assign instrucao_valida    = valida_q;
    assign erro_endereco       = erro_q;

endmodule
